// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: response-owner encoding
// and the helper that decides who owns next cycle's read data.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } own_e;

  // Owner of the response that appears one cycle after this grant; writes return nothing.
  function automatic own_e next_owner(input logic if_gnt, input logic dm_gnt, input logic dm_wen);
    own_e own;
    if (if_gnt) begin
      own = OWN_IF;
    end else if (dm_gnt && !dm_wen) begin
      own = OWN_DM;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating counter of consecutive cycles fetch has lost
// arbitration. 'sat' tells the arbiter that fetch must win this cycle.
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_r;

  // Count lost fetch cycles, holding at MAX; clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between
// instruction fetch (IF) and data memory access (DM). DM has priority as the
// older instruction. Define ARB_STARVE_GUARD_EN to force a fetch grant after
// MAX_WAIT consecutive lost cycles; otherwise DM priority is strict.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be at least 1");
  end

  logic if_gnt_s;
  logic dm_gnt_s;
  logic force_if_s;
  own_e resp_own_r;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req & ~if_gnt_s),
    .clr   (if_gnt_s | ~if_req),
    .sat   (force_if_s)
  );
`else
  assign force_if_s = 1'b0;
`endif

  // Grant: DM first, unless fetch has waited long enough to be forced through.
  always_comb begin
    if_gnt_s = 1'b0;
    dm_gnt_s = 1'b0;
    if (reset) begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end else if (dm_req && !(if_req && force_if_s)) begin
      dm_gnt_s = 1'b1;
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end
  end

  // Drive the memory port from the winner; fetch never writes.
  always_comb begin
    mem_en    = if_gnt_s | dm_gnt_s;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (dm_gnt_s) begin
      mem_we    = dm_wen;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt_s) begin
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = {DATA_W{1'b0}};
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Remember who owns the read data returning next cycle; reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_own_r <= OWN_NONE;
    end else begin
      resp_own_r <= next_owner(if_gnt_s, dm_gnt_s, dm_wen);
    end
  end

  assign if_gnt    = if_gnt_s;
  assign dm_gnt    = dm_gnt_s;
  // A response owed from before reset must not surface while reset is held.
  assign if_rvalid = (resp_own_r == OWN_IF) & ~reset;
  assign dm_rvalid = (resp_own_r == OWN_DM) & ~reset;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed plan followed by constrained-random
// traffic, each cycle compared against a rule-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_wen;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_wen    (dm_wen),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory attached to the port: single-port, synchronous read.
  logic [DW-1:0] tb_mem [0:1023];
  logic [DW-1:0] rd_q;
  assign mem_rdata = rd_q;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[11:2]] <= mem_wdata;
      else        rd_q <= tb_mem[mem_addr[11:2]];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:1023];
  int            wait_m;
  int            pend_own;   // 0 none, 1 fetch, 2 data
  logic [DW-1:0] pend_data;
  bit            e_if;
  bit            e_dm;
  int            errors;
  int            checks;
  int            if_gnt_cnt;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h0001_0001) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, compare, advance the model.
  task automatic cycle(input bit rs, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [31:0] dd);
    bit rv_if;
    bit rv_dm;
    reset = rs; if_req = ir; if_addr = ia;
    dm_req = dr; dm_wen = dw; dm_addr = da; dm_wdata = dd;
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rs) begin
      if (dr && ir) begin
`ifdef ARB_STARVE_GUARD_EN
        if (wait_m == MW) e_if = 1'b1;
        else              e_dm = 1'b1;
`else
        e_dm = 1'b1;
`endif
      end else if (dr) begin
        e_dm = 1'b1;
      end else if (ir) begin
        e_if = 1'b1;
      end
    end
    rv_if = (pend_own == 1) && !rs;
    rv_dm = (pend_own == 2) && !rs;
    #2;
    check("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
    check("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm});
    check("mem_en", {31'd0, mem_en}, {31'd0, (e_if | e_dm)});
    if (e_if || e_dm || rs) check("mem_we", {31'd0, mem_we}, {31'd0, (e_dm & dw)});
    if (e_dm) check("mem_addr_dm", mem_addr, da);
    if (e_if) check("mem_addr_if", mem_addr, ia);
    if (e_if) check("mem_wdata_if", mem_wdata, 32'd0);
    if (e_dm && dw) check("mem_wdata_dm", mem_wdata, dd);
    check("if_rvalid", {31'd0, if_rvalid}, {31'd0, rv_if});
    check("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, rv_dm});
    if (rv_if) check("if_rdata", if_rdata, pend_data);
    if (rv_dm) check("dm_rdata", dm_rdata, pend_data);
    if (if_gnt === 1'b1) if_gnt_cnt++;
    @(posedge clk);
    #1;
    if (rs) begin
      pend_own = 0;
      wait_m   = 0;
    end else begin
      if (e_if) begin
        pend_own  = 1;
        pend_data = ref_mem[ia[11:2]];
      end else if (e_dm && !dw) begin
        pend_own  = 2;
        pend_data = ref_mem[da[11:2]];
      end else begin
        pend_own = 0;
      end
      if (e_dm && dw) ref_mem[da[11:2]] = dd;
      if (ir && !e_if) wait_m = (wait_m < MW) ? wait_m + 1 : MW;
      else             wait_m = 0;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    bit            ip;
    bit            dp;
    bit            dw_r;
    bit            rs_r;
    logic [31:0]   ia_r;
    logic [31:0]   da_r;
    logic [31:0]   dd_r;
    int            exp_if_cnt;

    errors = 0; checks = 0; wait_m = 0; pend_own = 0; pend_data = 32'd0;
    if_gnt_cnt = 0; rd_q = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset with both requests raised: nothing may be granted.
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Fetch alone at 0x10, then its data.
    cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // Conflict: data read at 0x100 wins, fetch retries and wins next.
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'd0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // Write then fetch the same word.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    check("write_then_fetch", ref_mem[128], 32'hDEAD_BEEF);

    // Both held for 10 cycles: starvation guard behaviour.
    if_gnt_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h104, 32'd0);
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_if_cnt = 2;
`else
    exp_if_cnt = 0;
`endif
    check("held_if_grants", 32'(if_gnt_cnt), 32'(exp_if_cnt));

    // Reset the cycle after a data read grant: the response is dropped.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h300, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 32'd0);
    idle();

    // Fetch drops while waiting: no credit kept.
    cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'd0);
    cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h28, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h2C, 32'h1234_5678);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h2C, 32'd0);
    end
    idle();

    // Random traffic obeying the hold-until-granted handshake.
    ip = 1'b0; dp = 1'b0; dw_r = 1'b0;
    ia_r = 32'd0; da_r = 32'd0; dd_r = 32'd0;
    for (int n = 0; n < 400; n++) begin
      rs_r = ($urandom_range(0, 99) == 0);
      if (!ip) begin
        ip   = ($urandom_range(0, 99) < 60);
        ia_r = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      end
      if (!dp) begin
        dp   = ($urandom_range(0, 99) < 55);
        dw_r = ($urandom_range(0, 1) == 1);
        da_r = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        dd_r = $urandom;
      end
      cycle(rs_r, ip, ia_r, dp, dw_r, da_r, dd_r);
      if (e_if || rs_r) ip = 1'b0;
      if (e_dm || rs_r) dp = 1'b0;
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
